// File: rtl/spi_ram_ctrl_if.sv
// Bus between the SPI slave shifter and the spi_ram_ctrl memory back end.
// fsm_state mirrors the controller's read FSM for observation.
interface spi_ram_ctrl_if #(
    parameter int DATA_W = 8
);
    // rx_valid qualifies din for one cycle and is never stalled; dout/tx_valid
    // rise together and hold until the first rising edge that sees tx_ready=1.
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic              tx_ready;
    logic              rd_ovf_clr;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              rd_ovf;
    logic [1:0]        fsm_state;

    modport master (
        output din, rx_valid, tx_ready, rd_ovf_clr,
        input  dout, tx_valid, rd_ovf, fsm_state
    );

    modport slave (
        input  din, rx_valid, tx_ready, rd_ovf_clr,
        output dout, tx_valid, rd_ovf, fsm_state
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// SPI-slave memory back end: 2-bit opcode decode, DATA_W x MEM_DEPTH array, held read data.
// Optional AUTO_INC_EN: post-increment wr_addr/rd_addr on writes/accepted reads.
module spi_ram_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input logic           clk,
    input logic           rst_n,
    spi_ram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        TX   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] captured;
    logic [DATA_W-1:0] dout_q;
    logic              tx_valid_q;
    logic              rd_ovf_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_word;
    logic              rd_req;

    assign opcode      = bus.din[DATA_W+1:DATA_W];
    assign payload     = bus.din[DATA_W-1:0];
    assign cmd_addr    = payload[ADDR_W-1:0];
    assign wr_in_range = 32'(wr_addr) < MEM_DEPTH;
    assign rd_in_range = 32'(rd_addr) < MEM_DEPTH;
    assign rd_word     = rd_in_range ? mem[rd_addr] : '0;
    assign rd_req      = bus.rx_valid && (opcode == 2'b11);

    assign bus.dout      = dout_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.rd_ovf    = rd_ovf_q;
    assign bus.fsm_state = state;

    // Wrap is modulo MEM_DEPTH, so an odd-sized array never addresses its holes.
    function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
        if (32'(a) >= MEM_DEPTH - 1) return '0;
        return a + 1'b1;
    endfunction

    // The array is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && (opcode == 2'b01) && wr_in_range)
            mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            captured   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            rd_ovf_q   <= 1'b0;
        end else begin
            // Clear first so a same-cycle overrun below takes priority.
            if (bus.rd_ovf_clr) rd_ovf_q <= 1'b0;

            if (bus.rx_valid) begin
                case (opcode)
                    2'b00: wr_addr <= cmd_addr;
                    2'b01: begin
`ifdef AUTO_INC_EN
                        wr_addr <= inc_addr(wr_addr);
`endif
                    end
                    2'b10: rd_addr <= cmd_addr;
                    default: if (state != IDLE) rd_ovf_q <= 1'b1;
                endcase
            end

            case (state)
                IDLE: begin
                    if (rd_req) begin
                        captured <= rd_word;
`ifdef AUTO_INC_EN
                        rd_addr  <= inc_addr(rd_addr);
`endif
                        state    <= RD;
                    end
                end
                RD: begin
                    dout_q     <= captured;
                    tx_valid_q <= 1'b1;
                    state      <= TX;
                end
                TX: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
